// File: rtl/dds_pkg.sv
// Shared DDS definitions: DAC frame geometry, control bytes, driver states
// and the frame-assembly helper used by the SPI output stage.
package dds_pkg;

  localparam int DAC_FRAME_BITS = 24;
  localparam int DAC_DATA_BITS  = 16;

  localparam logic [7:0] DAC_CTRL_NORMAL = 8'h00;
  localparam logic [7:0] DAC_CTRL_PD_1K  = 8'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } dac_state_t;

  // Control byte on top, sample below; flip turns two's-complement into offset-binary.
  function automatic logic [DAC_FRAME_BITS-1:0] dac_frame(
    input logic [7:0]               ctrl,
    input logic [DAC_DATA_BITS-1:0] sample,
    input logic                     flip
  );
    return {ctrl, sample ^ {flip, 15'h0000}};
  endfunction

endpackage

// File: rtl/dac_sclk_tick.sv
// Half-period timer for the DAC serial clock: one-cycle tick every CLK_DIV
// cycles while enabled, restarting from zero whenever it is disabled.
module dac_sclk_tick
  import dds_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_r;

  // Half-period counter, held at zero outside the shifting phase
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 8'd0;
    end else if (!enable) begin
      cnt_r <= 8'd0;
    end else if (cnt_r == DIV_LAST) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  assign tick = enable & (cnt_r == DIV_LAST);

endmodule

// File: rtl/dac_spi_driver.sv
// Serialises one 16-bit DDS sample per frame to a DAC8551-style SPI DAC:
// 24-bit frame (control byte + data), MSB first, SYNC active low.
module dac_spi_driver
  import dds_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter logic [7:0]  CTRL_BYTE   = DAC_CTRL_NORMAL,
  parameter bit          OFFSET_FLIP = 1'b0,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [4:0] BIT_LAST = 5'(DAC_FRAME_BITS - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  dac_state_t                state_r, state_nxt;
  logic [DAC_FRAME_BITS-1:0] shift_r, shift_nxt;
  logic [4:0]                bit_cnt_r, bit_cnt_nxt;
  logic [7:0]                gap_cnt_r, gap_cnt_nxt;
  logic                      sclk_r, sclk_nxt;
  logic                      sync_n_r, sync_n_nxt;
  logic                      busy_r, busy_nxt;
  logic                      frame_done_r, frame_done_nxt;
  logic                      tick_s;
  logic                      accept_s;

  assign sample_ready = (state_r == IDLE) & ~reset;
  assign accept_s     = sample_valid & sample_ready;

  dac_sclk_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_tick (
    .clk   (clk),
    .reset (reset),
    .enable(state_r == SHIFT),
    .tick  (tick_s)
  );

  // Next-state and next-output logic; SCLK falls mid-bit and rises to advance the shift
  always_comb begin
    state_nxt      = state_r;
    shift_nxt      = shift_r;
    bit_cnt_nxt    = bit_cnt_r;
    gap_cnt_nxt    = gap_cnt_r;
    sclk_nxt       = sclk_r;
    sync_n_nxt     = sync_n_r;
    frame_done_nxt = 1'b0;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt   = SHIFT;
          shift_nxt   = dac_frame(CTRL_BYTE, sample_in, OFFSET_FLIP);
          bit_cnt_nxt = 5'd0;
          sclk_nxt    = 1'b1;
          sync_n_nxt  = 1'b0;
        end else begin
          sclk_nxt   = 1'b1;
          sync_n_nxt = 1'b1;
        end
      end

      SHIFT: begin
        if (!tick_s) begin
          sclk_nxt = sclk_r;
        end else if (sclk_r) begin
          sclk_nxt = 1'b0;
        end else if (bit_cnt_r == BIT_LAST) begin
          state_nxt      = GAP;
          sclk_nxt       = 1'b1;
          sync_n_nxt     = 1'b1;
          shift_nxt      = '0;
          bit_cnt_nxt    = 5'd0;
          gap_cnt_nxt    = 8'd0;
          frame_done_nxt = 1'b1;
        end else begin
          sclk_nxt    = 1'b1;
          bit_cnt_nxt = bit_cnt_r + 5'd1;
          shift_nxt   = {shift_r[DAC_FRAME_BITS-2:0], 1'b0};
        end
      end

      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = 8'd0;
        end else begin
          gap_cnt_nxt = gap_cnt_r + 8'd1;
        end
      end

      default: begin
        state_nxt   = IDLE;
        shift_nxt   = '0;
        bit_cnt_nxt = 5'd0;
        gap_cnt_nxt = 8'd0;
        sclk_nxt    = 1'b1;
        sync_n_nxt  = 1'b1;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset abandons any frame without a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      shift_r      <= '0;
      bit_cnt_r    <= 5'd0;
      gap_cnt_r    <= 8'd0;
      sclk_r       <= 1'b1;
      sync_n_r     <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      shift_r      <= shift_nxt;
      bit_cnt_r    <= bit_cnt_nxt;
      gap_cnt_r    <= gap_cnt_nxt;
      sclk_r       <= sclk_nxt;
      sync_n_r     <= sync_n_nxt;
      busy_r       <= busy_nxt;
      frame_done_r <= frame_done_nxt;
    end
  end

  // DIN is the frame MSB straight from the shift register, zero outside a frame
  assign dac_din    = shift_r[DAC_FRAME_BITS-1];
  assign dac_sclk   = sclk_r;
  assign dac_sync_n = sync_n_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule
